// File: rtl/mul_div_if.sv
// Handshake and result bus between the register file / control unit and the
// iterative multiply/divide unit.
interface mul_div_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 6
);
    logic              start;
    logic [1:0]        op;
    logic [WIDTH-1:0]  rs_val;
    logic [WIDTH-1:0]  rt_val;
    logic [ADDR_W-1:0] rd_in;
    logic              busy;
    logic              done;
    logic              wrt;
    logic [ADDR_W-1:0] rd;
    logic [WIDTH-1:0]  result;
    logic              div_by_zero;

    modport master (
        output start, op, rs_val, rt_val, rd_in,
        input  busy, done, wrt, rd, result, div_by_zero
    );

    modport slave (
        input  start, op, rs_val, rt_val, rd_in,
        output busy, done, wrt, rd, result, div_by_zero
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit that
// writes its result back to the register file as a one-cycle write pulse.
module mul_div_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 6
) (
    input logic         clk,
    input logic         rst,
    mul_div_if.slave    bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [1:0]        op_q, op_n;
    logic [WIDTH-1:0]  b_q, b_n;
    logic [WIDTH-1:0]  hi, hi_n;
    logic [WIDTH-1:0]  lo, lo_n;
    logic [ADDR_W-1:0] rd_lat, rd_lat_n;
    logic [ADDR_W-1:0] rd_q, rd_n;
    logic [WIDTH-1:0]  result_q, result_n;
    logic              dbz_q, dbz_n;
    logic              done_q, done_n;
    logic              busy_q, busy_n;
    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    shifted;
    logic [WIDTH:0]    trial;

    // hi:lo holds the running product (multiply) or remainder:quotient (divide).
    // The RUN cycle at cnt == WIDTH is the write-back step, after WIDTH iterations.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        op_n     = op_q;
        b_n      = b_q;
        hi_n     = hi;
        lo_n     = lo;
        rd_lat_n = rd_lat;
        rd_n     = rd_q;
        result_n = result_q;
        dbz_n    = dbz_q;
        done_n   = 1'b0;

        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : (WIDTH+1)'(0));
        shifted = {hi, lo[WIDTH-1]};
        trial   = shifted - {1'b0, b_q};

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    op_n     = bus.op;
                    b_n      = bus.rt_val;
                    lo_n     = bus.rs_val;
                    hi_n     = '0;
                    rd_lat_n = bus.rd_in;
                    cnt_n    = '0;
                    state_n  = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(WIDTH)) begin
                    result_n = op_q[0] ? hi : lo;
                    dbz_n    = op_q[1] && (b_q == '0);
                    rd_n     = rd_lat;
                    done_n   = 1'b1;
                    state_n  = DONE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    if (op_q[1]) begin
                        // Restore when the trial subtraction underflows.
                        hi_n = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                        lo_n = {lo[WIDTH-2:0], ~trial[WIDTH]};
                    end else begin
                        hi_n = sum[WIDTH:1];
                        lo_n = {sum[0], lo[WIDTH-1:1]};
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            b_q      <= '0;
            hi       <= '0;
            lo       <= '0;
            rd_lat   <= '0;
            rd_q     <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            op_q     <= op_n;
            b_q      <= b_n;
            hi       <= hi_n;
            lo       <= lo_n;
            rd_lat   <= rd_lat_n;
            rd_q     <= rd_n;
            result_q <= result_n;
            dbz_q    <= dbz_n;
            done_q   <= done_n;
            busy_q   <= busy_n;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.wrt         = done_q;
    assign bus.rd          = rd_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, result values, divide-by-zero,
// ignored start while busy, back-to-back operation and mid-run reset.
module tb_mul_div_unit;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 6;
    localparam int          LAT    = WIDTH + 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mul_div_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    mul_div_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation from IDLE and check the completion cycle LAT cycles later.
    // inj > 0 pulses a competing MUL 3x3 start just before iteration edge inj.
    task automatic do_op(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [ADDR_W-1:0] r, input logic [WIDTH-1:0] exp_res,
                         input logic exp_dbz, input int inj, input string tag);
        int bad;
        bus.start  = 1'b1;
        bus.op     = o;
        bus.rs_val = a;
        bus.rt_val = b;
        bus.rd_in  = r;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
        bus.rd_in  = ~r;
        bad = 0;
        for (int k = 1; k <= LAT; k++) begin
            if (k == inj) begin
                bus.start  = 1'b1;
                bus.op     = 2'b00;
                bus.rs_val = 3;
                bus.rt_val = 3;
                bus.rd_in  = 1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (k < LAT && (!bus.busy || bus.done || bus.wrt)) bad++;
        end
        check({tag, " run_cycles"}, 64'(bad), 64'd0);
        check({tag, " done"}, 64'(bus.done), 64'd1);
        check({tag, " wrt"}, 64'(bus.wrt), 64'd1);
        check({tag, " busy_in_done"}, 64'(bus.busy), 64'd1);
        check({tag, " result"}, 64'(bus.result), 64'(exp_res));
        check({tag, " rd"}, 64'(bus.rd), 64'(r));
        check({tag, " dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
    endtask

    // One edge after the done cycle: unit idle, outputs held.
    task automatic post_idle(input logic [WIDTH-1:0] exp_res, input logic [ADDR_W-1:0] exp_rd,
                             input logic exp_dbz, input string tag);
        @(posedge clk); #1;
        check({tag, " idle_done"}, 64'(bus.done), 64'd0);
        check({tag, " idle_wrt"}, 64'(bus.wrt), 64'd0);
        check({tag, " idle_busy"}, 64'(bus.busy), 64'd0);
        check({tag, " held_result"}, 64'(bus.result), 64'(exp_res));
        check({tag, " held_rd"}, 64'(bus.rd), 64'(exp_rd));
        check({tag, " held_dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"}, 64'(bus.busy), 64'd0);
        check({tag, " done"}, 64'(bus.done), 64'd0);
        check({tag, " wrt"}, 64'(bus.wrt), 64'd0);
        check({tag, " result"}, 64'(bus.result), 64'd0);
        check({tag, " rd"}, 64'(bus.rd), 64'd0);
        check({tag, " dbz"}, 64'(bus.div_by_zero), 64'd0);
    endtask

    initial begin
        int wrt_seen;
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.rs_val = '0;
        bus.rt_val = '0;
        bus.rd_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(2'b00, 7, 6, 9, 42, 1'b0, 0, "mul_7x6");
        post_idle(42, 9, 1'b0, "mul_7x6");

        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 32'h0000_0001, 1'b0, 0, "mul_max");
        post_idle(32'h0000_0001, 3, 1'b0, "mul_max");
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 32'hFFFF_FFFE, 1'b0, 0, "mulh_max");
        post_idle(32'hFFFF_FFFE, 4, 1'b0, "mulh_max");

        do_op(2'b10, 100, 7, 10, 14, 1'b0, 0, "div_100_7");
        post_idle(14, 10, 1'b0, "div_100_7");
        do_op(2'b11, 100, 7, 11, 2, 1'b0, 0, "rem_100_7");
        post_idle(2, 11, 1'b0, "rem_100_7");

        do_op(2'b10, 5, 0, 12, 32'hFFFF_FFFF, 1'b1, 0, "div_5_0");
        post_idle(32'hFFFF_FFFF, 12, 1'b1, "div_5_0");
        do_op(2'b11, 5, 0, 13, 5, 1'b1, 0, "rem_5_0");
        post_idle(5, 13, 1'b1, "rem_5_0");
        do_op(2'b01, 32'h8000_0000, 4, 14, 2, 1'b0, 0, "mulh_after_dbz");
        post_idle(2, 14, 1'b0, "mulh_after_dbz");

        do_op(2'b10, 100, 7, 20, 14, 1'b0, 5, "div_ignore_start");
        post_idle(14, 20, 1'b0, "div_ignore_start");
        do_op(2'b00, 3, 3, 21, 9, 1'b0, 0, "mul_back_to_back");
        post_idle(9, 21, 1'b0, "mul_back_to_back");

        // Reset and start together: reset wins.
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.rs_val = 2;
        bus.rt_val = 2;
        bus.rd_in = 7;
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        check_reset_outputs("rst_and_start");

        // Abort a MUL at iteration 10.
        bus.start  = 1'b1;
        bus.op     = 2'b00;
        bus.rs_val = 7;
        bus.rt_val = 6;
        bus.rd_in  = 5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort busy_before_rst", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("abort");
        wrt_seen = 0;
        for (int k = 0; k < 2 * LAT; k++) begin
            @(posedge clk); #1;
            if (bus.wrt || bus.busy) wrt_seen++;
        end
        check("abort no_wrt_pulse", 64'(wrt_seen), 64'd0);

        do_op(2'b00, 7, 6, 9, 42, 1'b0, 0, "mul_after_abort");
        post_idle(42, 9, 1'b0, "mul_after_abort");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
